// File: rtl/pwm_controller_pkg.sv
// Shared constants for the PWM subsystem: register map, CTRL bit positions,
// ID value, counter width and the SPI slave state type.
package pwm_controller_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] ADDR_CTRL   = 7'h00;
    localparam logic [6:0] ADDR_PRESC  = 7'h01;
    localparam logic [6:0] ADDR_PERIOD = 7'h02;
    localparam logic [6:0] ADDR_DUTY0  = 7'h03;
    localparam logic [6:0] ADDR_ID     = 7'h7F;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_LOAD_BIT = 7;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    typedef enum logic [1:0] {
        SPI_WAIT_NCS,
        SPI_ACTIVE,
        SPI_DONE
    } spi_state_e;

endpackage

// File: rtl/pwm_spi_slave.sv
// SPI mode-0 slave oversampled in the clk_i domain: synchronisers, SCK edge
// detect, 16-bit frame shifting, write strobe and read-data shift-out.
module pwm_spi_slave
    import pwm_controller_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_clk_i,
    input  logic       spi_ncs_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [6:0] addr_o,
    output logic [7:0] wdata_o,
    output logic       wr_o,
    output logic       rd_req_o,
    input  logic [7:0] rdata_i
);

    logic [1:0]  sck_s_q, ncs_s_q, mosi_s_q;
    logic        sck_prev_q;
    spi_state_e  state_q;
    logic [3:0]  bitcnt_q;
    logic [14:0] shift_q;
    logic [6:0]  addr_q;
    logic        rnw_q;
    logic        load_tx_q;
    logic [7:0]  tx_q;
    logic        miso_q;

    logic sck_s, ncs_s, mosi_s, rise, fall, in_frame;

    assign sck_s    = sck_s_q[1];
    assign ncs_s    = ncs_s_q[1];
    assign mosi_s   = mosi_s_q[1];
    assign rise     = sck_s & ~sck_prev_q;
    assign fall     = ~sck_s & sck_prev_q;
    assign in_frame = (state_q == SPI_ACTIVE) & ~ncs_s;

    // Address is complete on the 8th rise; bypass the capture register then.
    assign addr_o     = (bitcnt_q == 4'd7) ? {shift_q[5:0], mosi_s} : addr_q;
    assign wdata_o    = {shift_q[6:0], mosi_s};
    assign wr_o       = in_frame & rise & (bitcnt_q == 4'd15) & ~rnw_q;
    assign rd_req_o   = in_frame & rise & (bitcnt_q == 4'd7) & shift_q[6];
    assign spi_miso_o = miso_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_s_q    <= '0;
            ncs_s_q    <= '0;
            mosi_s_q   <= '0;
            sck_prev_q <= 1'b0;
            state_q    <= SPI_WAIT_NCS;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            load_tx_q  <= 1'b0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
        end else begin
            sck_s_q    <= {sck_s_q[0], spi_clk_i};
            ncs_s_q    <= {ncs_s_q[0], spi_ncs_i};
            mosi_s_q   <= {mosi_s_q[0], spi_mosi_i};
            sck_prev_q <= sck_s;

            if (ncs_s) begin
                bitcnt_q  <= '0;
                shift_q   <= '0;
                addr_q    <= '0;
                rnw_q     <= 1'b0;
                load_tx_q <= 1'b0;
                tx_q      <= '0;
                miso_q    <= 1'b0;
            end

            case (state_q)
                SPI_WAIT_NCS: begin
                    if (ncs_s) state_q <= SPI_ACTIVE;
                end
                SPI_ACTIVE: begin
                    if (!ncs_s) begin
                        // Register file answers one cycle after the request.
                        if (load_tx_q) begin
                            tx_q      <= rdata_i;
                            load_tx_q <= 1'b0;
                        end
                        if (rise) begin
                            shift_q  <= {shift_q[13:0], mosi_s};
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                addr_q    <= {shift_q[5:0], mosi_s};
                                rnw_q     <= shift_q[6];
                                load_tx_q <= shift_q[6];
                            end
                            if (bitcnt_q == 4'd15) state_q <= SPI_DONE;
                        end else if (fall && bitcnt_q >= 4'd8) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                SPI_DONE: begin
                    if (ncs_s) state_q <= SPI_ACTIVE;
                    else if (fall) miso_q <= 1'b0;
                end
                default: state_q <= SPI_WAIT_NCS;
            endcase
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// Multi-channel PWM generator with shadowed configuration registers written
// and read over an SPI mode-0 slave port.
module pwm_controller
    import pwm_controller_pkg::*;
#(
    parameter int unsigned PWM_INSTANCES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [PWM_INSTANCES-1:0] pwm_o,
    input  logic                     spi_clk_i,
    input  logic                     spi_ncs_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o
);

    logic [6:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic       rd_req;
    logic [7:0] rdata_d, rdata_q;

    pwm_spi_slave u_spi (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spi_clk_i  (spi_clk_i),
        .spi_ncs_i  (spi_ncs_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_miso_o (spi_miso_o),
        .addr_o     (addr),
        .wdata_o    (wdata),
        .wr_o       (wr),
        .rd_req_o   (rd_req),
        .rdata_i    (rdata_q)
    );

    logic             en_q, load_q;
    logic [CNT_W-1:0] presc_q, period_q, presc_act_q, period_act_q;
    logic [CNT_W-1:0] duty_q     [PWM_INSTANCES];
    logic [CNT_W-1:0] duty_act_q [PWM_INSTANCES];
    logic [CNT_W-1:0] psc_cnt_q, cnt_q;
    logic [PWM_INSTANCES-1:0] cmp, pwm_q;

    logic tick, wrap, ctrl_wr, apply;

    assign tick    = en_q && (psc_cnt_q == presc_act_q);
    assign wrap    = tick && (cnt_q == period_act_q);
    assign ctrl_wr = wr && (addr == ADDR_CTRL);
    // A CTRL write in the same cycle defers the transfer; LOAD stays pending.
    assign apply   = load_q && (!en_q || wrap) && !ctrl_wr;

    always_comb begin
        rdata_d = '0;
        case (addr)
            ADDR_CTRL: begin
                rdata_d[CTRL_EN_BIT]   = en_q;
                rdata_d[CTRL_LOAD_BIT] = load_q;
            end
            ADDR_PRESC:  rdata_d = presc_q;
            ADDR_PERIOD: rdata_d = period_q;
            ADDR_ID:     rdata_d = ID_VALUE;
            default: begin
                for (int unsigned i = 0; i < PWM_INSTANCES; i++) begin
                    if (addr == ADDR_DUTY0 + 7'(i)) rdata_d = duty_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q      <= '0;
            en_q         <= 1'b0;
            load_q       <= 1'b0;
            presc_q      <= '0;
            period_q     <= '0;
            presc_act_q  <= '0;
            period_act_q <= '0;
            for (int unsigned i = 0; i < PWM_INSTANCES; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            if (rd_req) rdata_q <= rdata_d;
            if (wr) begin
                case (addr)
                    ADDR_CTRL: begin
                        en_q   <= wdata[CTRL_EN_BIT];
                        load_q <= load_q | wdata[CTRL_LOAD_BIT];
                    end
                    ADDR_PRESC:  presc_q  <= wdata;
                    ADDR_PERIOD: period_q <= wdata;
                    default: begin
                        for (int unsigned i = 0; i < PWM_INSTANCES; i++) begin
                            if (addr == ADDR_DUTY0 + 7'(i)) duty_q[i] <= wdata;
                        end
                    end
                endcase
            end
            if (apply) begin
                load_q       <= 1'b0;
                presc_act_q  <= presc_q;
                period_act_q <= period_q;
                for (int unsigned i = 0; i < PWM_INSTANCES; i++) begin
                    duty_act_q[i] <= duty_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else if (!en_q) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else if (tick) begin
            psc_cnt_q <= '0;
            cnt_q     <= wrap ? '0 : cnt_q + 1'b1;
        end else begin
            psc_cnt_q <= psc_cnt_q + 1'b1;
        end
    end

    for (genvar n = 0; n < PWM_INSTANCES; n++) begin : g_ch
        assign cmp[n] = cnt_q < duty_act_q[n];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pwm_q <= '0;
        else       pwm_q <= en_q ? cmp : '0;
    end

    assign pwm_o = pwm_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Directed and randomized SPI register/PWM checks for pwm_controller against
// a register-level model and waveform statistics of pwm_o[0].
module tb_pwm_controller;

    localparam int HALF = 5;
    localparam int HMAX = 40000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_ncs = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic [0:0] pwm;

    pwm_controller #(.PWM_INSTANCES(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pwm_o      (pwm),
        .spi_clk_i  (spi_sck),
        .spi_ncs_i  (spi_ncs),
        .spi_mosi_i (spi_mosi),
        .spi_miso_o (spi_miso)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic hist [HMAX];
    int   last_rise_cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < HMAX) hist[cyc] = pwm[0];

    // Register-level model: shadow values as seen by reads
    logic       m_en;
    logic [7:0] m_presc, m_period, m_duty;

    task automatic model_reset();
        m_en = 1'b0; m_presc = '0; m_period = '0; m_duty = '0;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h00: m_en = d[0];
            7'h01: m_presc = d;
            7'h02: m_period = d;
            7'h03: m_duty = d;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        case (a)
            7'h00: return {7'b0, m_en};
            7'h01: return m_presc;
            7'h02: return m_period;
            7'h03: return m_duty;
            7'h7F: return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rx);
        rx = '0;
        spi_ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[15-i];
            repeat (HALF) @(negedge clk);
            if (i >= 8) rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            if (i == 15) last_rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_ncs = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        spi_frame({1'b0, a, d}, 16, dummy);
        model_write(a, d);
    endtask

    task automatic read_check(input string tag, input logic [6:0] a);
        logic [7:0] rx;
        spi_frame({1'b1, a, 8'h00}, 16, rx);
        check(tag, int'(rx), int'(model_read(a)));
    endtask

    function automatic int next_rise(input int k);
        for (int j = (k < 1 ? 1 : k); j < HMAX; j++)
            if (hist[j] === 1'b1 && hist[j-1] === 1'b0) return j;
        return -1;
    endfunction

    function automatic int prev_rise(input int k);
        for (int j = k; j >= 1; j--)
            if (hist[j] === 1'b1 && hist[j-1] === 1'b0) return j;
        return -1;
    endfunction

    function automatic int run_len(input int k, input logic v);
        int n = 0;
        if (k < 0) return -1;
        while (k + n < HMAX && hist[k+n] === v && n < 1000) n++;
        return n;
    endfunction

    function automatic int count_high(input int k0, input int len);
        int c = 0;
        for (int j = k0; j < k0 + len; j++) if (hist[j] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int r, e, k_old, k_new, pcyc, hp, mn;
        logic [7:0] rx, pr, pe, du, d;
        logic [6:0] a;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_miso", int'(spi_miso), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        read_check("id_read", 7'h7F);

        // 4 high / 4 low: tick every 2 clocks, count 0..3, duty 2
        spi_write(7'h01, 8'h01);
        spi_write(7'h02, 8'h03);
        spi_write(7'h03, 8'h02);
        spi_write(7'h00, 8'h81);
        repeat (40) @(negedge clk);
        r = next_rise(cyc - 34);
        check("base_high_run", run_len(r, 1'b1), 4);
        check("base_low_run", run_len(r + 4, 1'b0), 4);
        check("base_period", next_rise(r + 1) - r, 8);
        read_check("ctrl_after_load", 7'h00);

        // Shadow write without LOAD leaves the running duty alone
        spi_write(7'h03, 8'h03);
        repeat (20) @(negedge clk);
        r = next_rise(cyc - 20);
        check("shadow_no_effect", run_len(r, 1'b1), 4);
        spi_write(7'h00, 8'h81);
        e = last_rise_cyc + 3;
        repeat (40) @(negedge clk);
        k_old = prev_rise(e + 1);
        k_new = next_rise(e + 2);
        check("load_old_run", run_len(k_old, 1'b1), 4);
        check("load_new_run", run_len(k_new, 1'b1), 6);
        check("load_at_wrap", k_new - k_old, 8);

        spi_write(7'h03, 8'h00);
        spi_write(7'h00, 8'h81);
        repeat (40) @(negedge clk);
        check("duty0_low", count_high(cyc - 20, 16), 0);
        spi_write(7'h03, 8'h04);
        spi_write(7'h00, 8'h81);
        repeat (40) @(negedge clk);
        check("duty_gt_period_high", count_high(cyc - 20, 16), 16);
        spi_write(7'h00, 8'h00);
        e = last_rise_cyc + 3;
        repeat (10) @(negedge clk);
        check("en_clear_before", int'(hist[e-1]), 1);
        check("en_clear_after", int'(hist[e+2]), 0);
        check("en_clear_stays", count_high(e + 2, 10), 0);

        // Partial frame: 12 bits of a PERIOD write must be discarded
        spi_frame({1'b0, 7'h02, 8'hAA}, 12, rx);
        read_check("partial_period", 7'h02);
        spi_write(7'h02, 8'h05);
        read_check("after_partial", 7'h02);

        spi_write(7'h7F, 8'h00);
        spi_write(7'h10, 8'h55);
        read_check("id_ro", 7'h7F);
        read_check("unmapped_read", 7'h10);
        read_check("presc_intact", 7'h01);
        read_check("period_intact", 7'h02);
        read_check("duty_intact", 7'h03);

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 5))
                0: a = 7'h01;
                1: a = 7'h02;
                2: a = 7'h03;
                3: a = 7'h10;
                4: a = 7'h7F;
                default: a = 7'($urandom_range(4, 126));
            endcase
            d = 8'($urandom);
            spi_write(a, d);
            read_check("rand_rw", a);
        end

        for (int i = 0; i < 4; i++) begin
            pr = 8'($urandom_range(0, 2));
            pe = 8'($urandom_range(1, 6));
            du = 8'($urandom_range(0, int'(pe) + 2));
            spi_write(7'h01, pr);
            spi_write(7'h02, pe);
            spi_write(7'h03, du);
            spi_write(7'h00, 8'h81);
            repeat (100) @(negedge clk);
            pcyc = (int'(pe) + 1) * (int'(pr) + 1);
            mn = (int'(du) < int'(pe) + 1) ? int'(du) : int'(pe) + 1;
            hp = mn * (int'(pr) + 1);
            check("rand_duty_count", count_high(cyc - 3*pcyc - 2, 3*pcyc), 3*hp);
            read_check("rand_ctrl", 7'h00);
        end

        // Reset while running
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_pwm", int'(pwm), 0);
        check("midrun_reset_miso", int'(spi_miso), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        read_check("post_reset_ctrl", 7'h00);
        read_check("post_reset_period", 7'h02);
        check("post_reset_pwm", count_high(cyc - 50, 40), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
